trap_csr: RTL and testbench
===========================

// Module: trap_csr
// PURPOSE
//  Machine-mode trap CSR file and trap responder. Owns mstatus/mie/mip/mtvec/mscratch/mepc/mcause/mtval.
//  Feeds the trap unit: interrupt request/enable plus vector mode/base.
//  Consumes the trap unit's TRAP_EN/PC/CODE/JMP_TO and the pipeline's MRET.
//  Commits CSR side effects, then issues a one-cycle FLUSH with a redirect PC to fetch.
// PARAMETERS
//  MTVEC_RESET  32'h0000_0000  reset value of mtvec (base|mode)
//  SYNC_STAGES  2              flop stages on each asynchronous IRQ input (>=2)
// PORTS
//  CLK          in   1   clock
//  RST          in   1   synchronous reset, active-high
//  MEM_WAIT     in   1   pipeline stall; no trap/MRET/CSR-write commit while high
//  IRQ_EXT      in   1   async external interrupt level (mip.MEIP, bit 11)
//  IRQ_TIMER    in   1   async timer interrupt level (mip.MTIP, bit 7)
//  IRQ_SOFT     in   1   async software interrupt level (mip.MSIP, bit 3)
//  CSR_RD_ADDR  in   12  CSR read address
//  CSR_RD_DATA  out  32  combinational read data
//  CSR_WR_EN    in   1   CSR write strobe
//  CSR_WR_ADDR  in   12  CSR write address
//  CSR_WR_DATA  in   32  CSR write data
//  TRAP_EN      in   1   trap request from trap unit
//  TRAP_PC      in   32  faulting/interrupted PC
//  TRAP_CODE    in   32  cause value to store in mcause
//  TRAP_JMP_TO  in   32  handler address
//  MRET_EN      in   1   mret retiring
//  INT_ALLOW    out  1   mstatus.MIE
//  INT_EN       out  1   registered |(mip & mie)
//  INT_CODE     out  4   registered highest-priority pending cause
//  TRAP_VEC_MODE out 2   mtvec[1:0]
//  TRAP_VEC_BASE out 32  {mtvec[31:2],2'b0}
//  FLUSH        out  1   one-cycle pipeline flush (registered)
//  NEW_PC       out  32  redirect target, valid while FLUSH=1, else 0
// BEHAVIOUR
//  Reset: mstatus.MIE=0, MPIE=0; mie=0; mepc=0; mcause=0; mscratch=0; mtvec=MTVEC_RESET;
//   IRQ synchronisers=0; FLUSH=0; NEW_PC=0; INT_EN=0; INT_CODE=0; FSM=IDLE. RST overrides everything.
//  FSM: IDLE, REDIR.
//   IDLE, !MEM_WAIT, TRAP_EN: mepc<={TRAP_PC[31:2],2'b0}; mcause<=TRAP_CODE; MPIE<=MIE; MIE<=0;
//    NEW_PC<=TRAP_JMP_TO; FLUSH<=1; go REDIR.
//   IDLE, !MEM_WAIT, MRET_EN, !TRAP_EN: MIE<=MPIE; MPIE<=1; NEW_PC<=mepc; FLUSH<=1; go REDIR.
//   TRAP_EN and MRET_EN together: trap wins; MRET dropped.
//   REDIR: FLUSH=1 for exactly this cycle, even if MEM_WAIT=1. TRAP_EN/MRET_EN ignored. Next: IDLE, FLUSH<=0, NEW_PC<=0.
//   Latency: request-accept edge -> FLUSH high the following cycle (1 cycle).
//  CSR map (reads of any other address = 0; writes ignored):
//   300 mstatus: MIE[3], MPIE[7] rw; MPP[12:11] reads 2'b11; other bits 0.
//   304 mie: bits 11/7/3 rw; others 0.
//   305 mtvec: [31:2] rw; mode WARL, wr 0/1 kept, 2/3 stored as 0.
//   340 mscratch rw.  341 mepc rw, [1:0] forced 0.  342 mcause rw.  343 mtval reads 0.
//   344 mip: read-only.
//  CSR writes commit only when !MEM_WAIT.
//  Same-cycle trap/MRET commit: trap/MRET update of mstatus/mepc/mcause wins over the CSR write; writes to other CSRs still commit.
//  Interrupts: each IRQ passes SYNC_STAGES flops into mip. pend = mip & mie. INT_EN <= |pend.
//   INT_CODE <= 11 if pend[11], else 3 if pend[3], else 7 if pend[7], else 0.
//   INT_EN/INT_CODE update every cycle regardless of MEM_WAIT.
//  No arithmetic beyond masking; all registers 32-bit.
// TESTING
//  1. Reset with MTVEC_RESET=32'h8000_0001 -> TRAP_VEC_BASE=8000_0000, TRAP_VEC_MODE=1, FLUSH=0, INT_EN=0, mstatus reads 0000_1800.
//  2. MIE=1; TRAP_EN, PC=0000_0104, CODE=2, JMP_TO=8000_0000 -> next cycle FLUSH=1 for 1 cycle, NEW_PC=8000_0000; mepc=104, mcause=2, MIE=0, MPIE=1.
//  3. After test 2, MRET_EN -> FLUSH 1 cycle, NEW_PC=0000_0104; MIE=1, MPIE=1.
//  4. mie=0x800; IRQ_EXT=1 and IRQ_TIMER=1 with mie.7=0 -> INT_EN=1 after SYNC_STAGES+1 cycles, INT_CODE=11; mie=0x080 -> INT_CODE=7.
//  5. TRAP_EN with MEM_WAIT=1 for 3 cycles -> no FLUSH, CSRs unchanged; MEM_WAIT drop -> trap commits; TRAP_EN+MRET_EN same cycle -> only trap effects.
//  6. Write mtvec=0000_1003 -> reads 0000_1000. Write mepc=0000_0207 -> reads 0000_0204. Write mip -> unchanged. RST asserted while in REDIR -> FLUSH=0 next cycle, all reset values.

Source files
------------

// File: rtl/trap_csr.sv
// Machine-mode trap CSR file (mstatus/mie/mip/mtvec/mscratch/mepc/mcause/mtval) and trap/MRET responder.
// Latency: trap/MRET accept edge -> one-cycle registered FLUSH with NEW_PC; IRQs reach mip after SYNC_STAGES flops.
module trap_csr #(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        MEM_WAIT,
    input  logic        IRQ_EXT,
    input  logic        IRQ_TIMER,
    input  logic        IRQ_SOFT,
    input  logic [11:0] CSR_RD_ADDR,
    output logic [31:0] CSR_RD_DATA,
    input  logic        CSR_WR_EN,
    input  logic [11:0] CSR_WR_ADDR,
    input  logic [31:0] CSR_WR_DATA,
    input  logic        TRAP_EN,
    input  logic [31:0] TRAP_PC,
    input  logic [31:0] TRAP_CODE,
    input  logic [31:0] TRAP_JMP_TO,
    input  logic        MRET_EN,
    output logic        INT_ALLOW,
    output logic        INT_EN,
    output logic [3:0]  INT_CODE,
    output logic [1:0]  TRAP_VEC_MODE,
    output logic [31:0] TRAP_VEC_BASE,
    output logic        FLUSH,
    output logic [31:0] NEW_PC
);

    localparam logic [11:0] A_MSTATUS  = 12'h300;
    localparam logic [11:0] A_MIE      = 12'h304;
    localparam logic [11:0] A_MTVEC    = 12'h305;
    localparam logic [11:0] A_MSCRATCH = 12'h340;
    localparam logic [11:0] A_MEPC     = 12'h341;
    localparam logic [11:0] A_MCAUSE   = 12'h342;
    localparam logic [11:0] A_MTVAL    = 12'h343;
    localparam logic [11:0] A_MIP      = 12'h344;
    localparam logic [31:0] IRQ_MASK   = 32'h0000_0888;

    typedef enum logic {IDLE, REDIR} state_t;

    state_t                 state_q, state_d;
    logic                   mie_bit_q, mie_bit_d;
    logic                   mpie_q, mpie_d;
    logic [31:0]            mie_q, mie_d;
    logic [31:0]            mtvec_q, mtvec_d;
    logic [31:0]            mscratch_q, mscratch_d;
    logic [31:0]            mepc_q, mepc_d;
    logic [31:0]            mcause_q, mcause_d;
    logic                   flush_q, flush_d;
    logic [31:0]            new_pc_q, new_pc_d;
    logic                   int_en_q, int_en_d;
    logic [3:0]             int_code_q, int_code_d;
    logic [SYNC_STAGES-1:0] ext_sync_q, ext_sync_d;
    logic [SYNC_STAGES-1:0] tmr_sync_q, tmr_sync_d;
    logic [SYNC_STAGES-1:0] sw_sync_q, sw_sync_d;

    logic [31:0] mip;
    logic [31:0] pend;
    logic        wr_ok;
    logic        take_trap;
    logic        take_mret;
    logic        unused_bits;

    assign mip = {20'b0, ext_sync_q[SYNC_STAGES-1], 3'b0, tmr_sync_q[SYNC_STAGES-1],
                  3'b0, sw_sync_q[SYNC_STAGES-1], 3'b0};
    assign pend        = mip & mie_q;
    assign wr_ok       = CSR_WR_EN && !MEM_WAIT;
    assign take_trap   = (state_q == IDLE) && !MEM_WAIT && TRAP_EN;
    assign take_mret   = (state_q == IDLE) && !MEM_WAIT && MRET_EN && !TRAP_EN;
    assign unused_bits = ^TRAP_PC[1:0];

    always_comb begin
        CSR_RD_DATA = 32'h0;
        case (CSR_RD_ADDR)
            A_MSTATUS:  CSR_RD_DATA = {19'b0, 2'b11, 3'b0, mpie_q, 3'b0, mie_bit_q, 3'b0};
            A_MIE:      CSR_RD_DATA = mie_q;
            A_MTVEC:    CSR_RD_DATA = mtvec_q;
            A_MSCRATCH: CSR_RD_DATA = mscratch_q;
            A_MEPC:     CSR_RD_DATA = mepc_q;
            A_MCAUSE:   CSR_RD_DATA = mcause_q;
            A_MTVAL:    CSR_RD_DATA = 32'h0;
            A_MIP:      CSR_RD_DATA = mip;
            default:    CSR_RD_DATA = 32'h0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        mie_bit_d  = mie_bit_q;
        mpie_d     = mpie_q;
        mie_d      = mie_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        flush_d    = 1'b0;
        new_pc_d   = 32'h0;
        ext_sync_d = {ext_sync_q[SYNC_STAGES-2:0], IRQ_EXT};
        tmr_sync_d = {tmr_sync_q[SYNC_STAGES-2:0], IRQ_TIMER};
        sw_sync_d  = {sw_sync_q[SYNC_STAGES-2:0], IRQ_SOFT};
        int_en_d   = |pend;
        int_code_d = pend[11] ? 4'd11 : pend[3] ? 4'd3 : pend[7] ? 4'd7 : 4'd0;

        // Plain CSR writes first; a same-cycle trap/MRET below overrides mstatus/mepc/mcause.
        if (wr_ok) begin
            case (CSR_WR_ADDR)
                A_MSTATUS: begin
                    mie_bit_d = CSR_WR_DATA[3];
                    mpie_d    = CSR_WR_DATA[7];
                end
                A_MIE:      mie_d      = CSR_WR_DATA & IRQ_MASK;
                A_MTVEC:    mtvec_d    = {CSR_WR_DATA[31:2], 1'b0, (CSR_WR_DATA[1:0] == 2'b01)};
                A_MSCRATCH: mscratch_d = CSR_WR_DATA;
                A_MEPC:     mepc_d     = {CSR_WR_DATA[31:2], 2'b00};
                A_MCAUSE:   mcause_d   = CSR_WR_DATA;
                default: ;
            endcase
        end

        case (state_q)
            IDLE: begin
                if (take_trap) begin
                    mepc_d    = {TRAP_PC[31:2], 2'b00};
                    mcause_d  = TRAP_CODE;
                    mpie_d    = mie_bit_q;
                    mie_bit_d = 1'b0;
                    new_pc_d  = TRAP_JMP_TO;
                    flush_d   = 1'b1;
                    state_d   = REDIR;
                end else if (take_mret) begin
                    mepc_d    = mepc_q;
                    mcause_d  = mcause_q;
                    mie_bit_d = mpie_q;
                    mpie_d    = 1'b1;
                    new_pc_d  = mepc_q;
                    flush_d   = 1'b1;
                    state_d   = REDIR;
                end
            end
            REDIR: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            mie_bit_q  <= 1'b0;
            mpie_q     <= 1'b0;
            mie_q      <= 32'h0;
            mtvec_q    <= MTVEC_RESET;
            mscratch_q <= 32'h0;
            mepc_q     <= 32'h0;
            mcause_q   <= 32'h0;
            flush_q    <= 1'b0;
            new_pc_q   <= 32'h0;
            int_en_q   <= 1'b0;
            int_code_q <= 4'd0;
            ext_sync_q <= '0;
            tmr_sync_q <= '0;
            sw_sync_q  <= '0;
        end else begin
            state_q    <= state_d;
            mie_bit_q  <= mie_bit_d;
            mpie_q     <= mpie_d;
            mie_q      <= mie_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            flush_q    <= flush_d;
            new_pc_q   <= new_pc_d;
            int_en_q   <= int_en_d;
            int_code_q <= int_code_d;
            ext_sync_q <= ext_sync_d;
            tmr_sync_q <= tmr_sync_d;
            sw_sync_q  <= sw_sync_d;
        end
    end

    assign INT_ALLOW     = mie_bit_q;
    assign INT_EN        = int_en_q;
    assign INT_CODE      = int_code_q;
    assign TRAP_VEC_MODE = mtvec_q[1:0];
    assign TRAP_VEC_BASE = {mtvec_q[31:2], 2'b00};
    assign FLUSH         = flush_q;
    assign NEW_PC        = new_pc_q;

endmodule

// File: tb/tb_trap_csr.sv
// Directed bench for trap_csr: redirects are scoreboarded through a queue drained by a FLUSH monitor,
// CSR/interrupt state is checked directly against hand-computed constants.
module tb_trap_csr;

    logic        CLK = 1'b0;
    logic        RST, MEM_WAIT, IRQ_EXT, IRQ_TIMER, IRQ_SOFT;
    logic [11:0] CSR_RD_ADDR, CSR_WR_ADDR;
    logic [31:0] CSR_RD_DATA, CSR_WR_DATA;
    logic        CSR_WR_EN, TRAP_EN, MRET_EN;
    logic [31:0] TRAP_PC, TRAP_CODE, TRAP_JMP_TO;
    logic        INT_ALLOW, INT_EN, FLUSH;
    logic [3:0]  INT_CODE;
    logic [1:0]  TRAP_VEC_MODE;
    logic [31:0] TRAP_VEC_BASE, NEW_PC;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] exp_q[$];

    trap_csr #(.MTVEC_RESET(32'h8000_0001), .SYNC_STAGES(2)) dut (
        .CLK(CLK), .RST(RST), .MEM_WAIT(MEM_WAIT),
        .IRQ_EXT(IRQ_EXT), .IRQ_TIMER(IRQ_TIMER), .IRQ_SOFT(IRQ_SOFT),
        .CSR_RD_ADDR(CSR_RD_ADDR), .CSR_RD_DATA(CSR_RD_DATA),
        .CSR_WR_EN(CSR_WR_EN), .CSR_WR_ADDR(CSR_WR_ADDR), .CSR_WR_DATA(CSR_WR_DATA),
        .TRAP_EN(TRAP_EN), .TRAP_PC(TRAP_PC), .TRAP_CODE(TRAP_CODE), .TRAP_JMP_TO(TRAP_JMP_TO),
        .MRET_EN(MRET_EN), .INT_ALLOW(INT_ALLOW), .INT_EN(INT_EN), .INT_CODE(INT_CODE),
        .TRAP_VEC_MODE(TRAP_VEC_MODE), .TRAP_VEC_BASE(TRAP_VEC_BASE),
        .FLUSH(FLUSH), .NEW_PC(NEW_PC)
    );

    always #5 CLK = ~CLK;

    // Every FLUSH cycle must match the next queued redirect; outside FLUSH, NEW_PC must idle at 0.
    always @(negedge CLK) begin
        if (FLUSH) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL flush_unexpected: FLUSH=1 NEW_PC=%h, no redirect expected", NEW_PC);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (NEW_PC !== e) begin
                    miscompares++;
                    $display("FAIL flush_new_pc: got %h expected %h", NEW_PC, e);
                end
            end
        end else if (NEW_PC !== 32'h0) begin
            vectors++;
            miscompares++;
            $display("FAIL new_pc_idle: got %h expected 00000000", NEW_PC);
        end
    end

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic rd(input string name, input logic [11:0] addr, input logic [31:0] exp);
        CSR_RD_ADDR = addr;
        #1;
        chk(name, CSR_RD_DATA, exp);
    endtask

    task automatic wr(input logic [11:0] addr, input logic [31:0] data);
        CSR_WR_EN = 1'b1; CSR_WR_ADDR = addr; CSR_WR_DATA = data;
        tick();
        CSR_WR_EN = 1'b0;
    endtask

    initial begin
        RST = 1'b1; MEM_WAIT = 1'b0; IRQ_EXT = 1'b0; IRQ_TIMER = 1'b0; IRQ_SOFT = 1'b0;
        CSR_RD_ADDR = 12'h0; CSR_WR_EN = 1'b0; CSR_WR_ADDR = 12'h0; CSR_WR_DATA = 32'h0;
        TRAP_EN = 1'b0; MRET_EN = 1'b0; TRAP_PC = 32'h0; TRAP_CODE = 32'h0; TRAP_JMP_TO = 32'h0;
        tick(3);
        RST = 1'b0;

        // Reset state
        chk("rst_vec_base", TRAP_VEC_BASE, 32'h8000_0000);
        chk("rst_vec_mode", {30'b0, TRAP_VEC_MODE}, 32'd1);
        chk("rst_flush", {31'b0, FLUSH}, 32'd0);
        chk("rst_int_en", {31'b0, INT_EN}, 32'd0);
        chk("rst_int_allow", {31'b0, INT_ALLOW}, 32'd0);
        rd("rst_mstatus", 12'h300, 32'h0000_1800);
        rd("rst_mtvec", 12'h305, 32'h8000_0001);
        rd("rst_mepc", 12'h341, 32'h0);

        // Trap entry with MIE=1
        wr(12'h300, 32'h0000_0008);
        chk("mie_set", {31'b0, INT_ALLOW}, 32'd1);
        rd("mstatus_mie", 12'h300, 32'h0000_1808);
        TRAP_EN = 1'b1; TRAP_PC = 32'h0000_0104; TRAP_CODE = 32'd2; TRAP_JMP_TO = 32'h8000_0000;
        exp_q.push_back(32'h8000_0000);
        tick();
        TRAP_EN = 1'b0;
        tick();
        rd("trap_mepc", 12'h341, 32'h0000_0104);
        rd("trap_mcause", 12'h342, 32'h0000_0002);
        rd("trap_mstatus", 12'h300, 32'h0000_1880);

        // MRET back to mepc
        MRET_EN = 1'b1;
        exp_q.push_back(32'h0000_0104);
        tick();
        MRET_EN = 1'b0;
        tick();
        rd("mret_mstatus", 12'h300, 32'h0000_1888);

        // Interrupt sync latency and priority
        wr(12'h304, 32'h0000_0800);
        rd("mie_800", 12'h304, 32'h0000_0800);
        IRQ_EXT = 1'b1; IRQ_TIMER = 1'b1;
        tick(2);
        chk("int_en_early", {31'b0, INT_EN}, 32'd0);
        tick();
        chk("int_en_ext", {31'b0, INT_EN}, 32'd1);
        chk("int_code_ext", {28'b0, INT_CODE}, 32'd11);
        rd("mip_ext_tmr", 12'h344, 32'h0000_0880);
        wr(12'h304, 32'h0000_0080);
        tick();
        chk("int_code_tmr", {28'b0, INT_CODE}, 32'd7);
        IRQ_SOFT = 1'b1;
        wr(12'h304, 32'h0000_0088);
        tick(3);
        chk("int_code_soft", {28'b0, INT_CODE}, 32'd3);
        IRQ_EXT = 1'b0; IRQ_TIMER = 1'b0; IRQ_SOFT = 1'b0;
        wr(12'h304, 32'h0000_0000);
        tick(3);
        chk("int_en_clear", {31'b0, INT_EN}, 32'd0);

        // Trap held off by MEM_WAIT, CSR write held off too
        MEM_WAIT = 1'b1; TRAP_EN = 1'b1;
        TRAP_PC = 32'h0000_0208; TRAP_CODE = 32'h8000_000B; TRAP_JMP_TO = 32'h8000_0040;
        CSR_WR_EN = 1'b1; CSR_WR_ADDR = 12'h340; CSR_WR_DATA = 32'hDEAD_BEEF;
        tick(3);
        CSR_WR_EN = 1'b0;
        rd("wait_mepc", 12'h341, 32'h0000_0104);
        rd("wait_mcause", 12'h342, 32'h0000_0002);
        rd("wait_mscratch", 12'h340, 32'h0);
        exp_q.push_back(32'h8000_0040);
        MEM_WAIT = 1'b0;
        tick();
        TRAP_EN = 1'b0;
        tick();
        rd("wait_trap_mepc", 12'h341, 32'h0000_0208);
        rd("wait_trap_mcause", 12'h342, 32'h8000_000B);
        rd("wait_trap_mstatus", 12'h300, 32'h0000_1880);

        // Trap and MRET together, plus competing CSR writes
        TRAP_EN = 1'b1; MRET_EN = 1'b1;
        TRAP_PC = 32'h0000_0300; TRAP_CODE = 32'd5; TRAP_JMP_TO = 32'h8000_0080;
        exp_q.push_back(32'h8000_0080);
        wr(12'h342, 32'h0000_1234);
        TRAP_EN = 1'b0; MRET_EN = 1'b0;
        wr(12'h340, 32'hCAFE_F00D);
        rd("both_mepc", 12'h341, 32'h0000_0300);
        rd("both_mcause", 12'h342, 32'h0000_0005);
        rd("both_mstatus", 12'h300, 32'h0000_1800);
        rd("both_mscratch", 12'h340, 32'hCAFE_F00D);

        // WARL / read-only fields
        wr(12'h305, 32'h0000_1003);
        rd("mtvec_mode3", 12'h305, 32'h0000_1000);
        chk("vec_mode_0", {30'b0, TRAP_VEC_MODE}, 32'd0);
        wr(12'h305, 32'h0000_2001);
        rd("mtvec_mode1", 12'h305, 32'h0000_2001);
        chk("vec_base", TRAP_VEC_BASE, 32'h0000_2000);
        wr(12'h341, 32'h0000_0207);
        rd("mepc_align", 12'h341, 32'h0000_0204);
        wr(12'h344, 32'hFFFF_FFFF);
        rd("mip_ro", 12'h344, 32'h0);
        wr(12'h343, 32'h1234_5678);
        rd("mtval_zero", 12'h343, 32'h0);
        rd("unmapped", 12'h345, 32'h0);

        // Reset while in REDIR
        TRAP_EN = 1'b1; TRAP_PC = 32'h0000_0400; TRAP_CODE = 32'd7; TRAP_JMP_TO = 32'h8000_00C0;
        exp_q.push_back(32'h8000_00C0);
        tick();
        TRAP_EN = 1'b0; RST = 1'b1;
        tick();
        chk("rst_redir_flush", {31'b0, FLUSH}, 32'd0);
        rd("rst_redir_mepc", 12'h341, 32'h0);
        rd("rst_redir_mcause", 12'h342, 32'h0);
        rd("rst_redir_mstatus", 12'h300, 32'h0000_1800);
        rd("rst_redir_mtvec", 12'h305, 32'h8000_0001);
        rd("rst_redir_mscratch", 12'h340, 32'h0);
        RST = 1'b0;
        tick(3);

        chk("redirects_left", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
